// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an NxN output-stationary systolic array: sequences one tile
// (clear, stream K vector pairs, flush the wavefront) and delays lane i by i cycles.
module systolic_skew_feeder #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N*W-1:0] a_feed,
    output logic [N*W-1:0] b_feed,
    output logic           pe_rst,
    output logic           busy,
    output logic           done
);

    localparam int FLUSH_CYC = 2 * (N - 1);
    localparam int XW        = $clog2(K + 1);
    localparam int FW_RAW    = $clog2(2 * N - 1);
    localparam int FW        = (FW_RAW < 1) ? 1 : FW_RAW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            xfer;

    assign xfer = (state_q == STREAM) && in_valid;

    always_comb begin
        state_d     = state_q;
        xfer_cnt_d  = xfer_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                state_d    = STREAM;
                xfer_cnt_d = '0;
            end
            STREAM: begin
                if (xfer) begin
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                    if (xfer_cnt_q == XW'(K - 1)) begin
                        flush_cnt_d = '0;
                        // With N=1 there is no wavefront to drain.
                        state_d     = (FLUSH_CYC == 0) ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FW'(FLUSH_CYC - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            xfer_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            xfer_cnt_q  <= xfer_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign pe_rst   = rst && (state_q != CLEAR);

    // Lane i is an (i+1)-deep chain; zeros are injected whenever no transfer occurs.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] a_sr_q [0:i];
        logic [W-1:0] a_sr_d [0:i];
        logic [W-1:0] b_sr_q [0:i];
        logic [W-1:0] b_sr_d [0:i];

        always_comb begin
            a_sr_d[0] = xfer ? a_in[i*W +: W] : '0;
            b_sr_d[0] = xfer ? b_in[i*W +: W] : '0;
            for (int d = 1; d <= i; d++) begin
                a_sr_d[d] = a_sr_q[d-1];
                b_sr_d[d] = b_sr_q[d-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int d = 0; d <= i; d++) begin
                    a_sr_q[d] <= '0;
                    b_sr_q[d] <= '0;
                end
            end else begin
                for (int d = 0; d <= i; d++) begin
                    a_sr_q[d] <= a_sr_d[d];
                    b_sr_q[d] <= b_sr_d[d];
                end
            end
        end

        assign a_feed[i*W +: W] = a_sr_q[i];
        assign b_feed[i*W +: W] = b_sr_q[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a small behavioural 4x4 PE array
// fed by the skewed outputs.
module tb_systolic_skew_feeder;

    localparam int N = 4;
    localparam int W = 8;
    localparam int K = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N*W-1:0] a_feed;
    logic [N*W-1:0] b_feed;
    logic           pe_rst;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_err    = 0;

    int acc [N][N];
    int ar  [N][N];
    int br  [N][N];

    systolic_skew_feeder #(.N(N), .W(W), .K(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .a_feed   (a_feed),
        .b_feed   (b_feed),
        .pe_rst   (pe_rst),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Output-stationary PE array: a moves east, b moves south, acc += a*b.
    always @(posedge clk) begin : pe_model
        int aw, bn;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                aw = (j == 0) ? int'(a_feed[i*W +: W]) : ar[i][j-1];
                bn = (i == 0) ? int'(b_feed[j*W +: W]) : br[i-1][j];
                ar[i][j]  <= aw;
                br[i][j]  <= bn;
                acc[i][j] <= (!pe_rst) ? 0 : acc[i][j] + aw * bn;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: A=identity, B=1..16; mode 1: constant lanes {1,2,3,4}/{5,6,7,8}.
    // Vectors past K carry junk that must never reach the array.
    task automatic drive(input int mode, input int k);
        for (int l = 0; l < N; l++) begin
            if (k >= K) begin
                a_in[l*W +: W] = 8'hA5;
                b_in[l*W +: W] = 8'h5A;
            end else if (mode == 1) begin
                a_in[l*W +: W] = W'(l + 1);
                b_in[l*W +: W] = W'(l + 5);
            end else begin
                a_in[l*W +: W] = (l == k) ? W'(1) : W'(0);
                b_in[l*W +: W] = W'(k * N + l + 1);
            end
        end
    endtask

    task automatic run_tile(input int mode, input int bub_len, input bit flush_start,
                            input int exp_lat);
        int n, xf, bub, t0, t3;
        bit xnow, was_bub;
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        check("clr_pe_rst", pe_rst, 0);
        check("clr_busy", busy, 1);
        check("clr_ready", in_ready, 0);
        n = 0; xf = 0; bub = 0; t0 = -1; t3 = -1;
        while (!done && n < 60) begin
            was_bub = 1'b0;
            if (in_ready && xf == 2 && bub < bub_len) begin
                in_valid = 1'b0;
                bub++;
                was_bub = 1'b1;
            end else begin
                in_valid = 1'b1;
                drive(mode, xf);
            end
            start = flush_start && (n == 7);
            xnow  = in_valid && in_ready;
            tick();
            n++;
            if (xnow) xf++;
            if (was_bub) begin
                check("bub_cnt", dut.xfer_cnt_q, 2);
                check("bub_a0", a_feed[W-1:0], 0);
                check("bub_b0", b_feed[W-1:0], 0);
            end
            if (mode == 1) begin
                if (t0 < 0 && a_feed[W-1:0] == 1) t0 = n;
                if (t3 < 0 && a_feed[3*W +: W] == 4) t3 = n;
            end
        end
        start = 1'b0;
        check("done_lat", n, exp_lat);
        check("xfers", xf, K);
        if (mode == 1) begin
            check("lane0_time", t0, 2);
            check("lane3_skew", t3 - t0, 3);
        end
        tick();
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        if (mode == 0) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    check($sformatf("pe_%0d_%0d", i, j), acc[i][j], i * N + j + 1);
        end
        if (flush_start) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("idle_ready", in_ready, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        #1;
        check("rst_pe_rst", pe_rst, 0);
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_afeed", a_feed, 0);
        check("rst_bfeed", b_feed, 0);
        rst = 1'b1;
        #1;
        check("idle_pe_rst", pe_rst, 1);
        tick();

        run_tile(1, 0, 1'b0, 11);
        run_tile(0, 0, 1'b0, 11);
        run_tile(0, 2, 1'b0, 13);

        // Abort in the third STREAM cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        drive(0, 0);
        tick();
        drive(0, 1);
        tick();
        drive(0, 2);
        tick();
        check("abort_in_stream", in_ready, 1);
        rst = 1'b0;
        #1;
        check("abort_pe_rst_comb", pe_rst, 0);
        tick();
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 0);
        check("abort_done", done, 0);
        check("abort_afeed", a_feed, 0);
        check("abort_bfeed", b_feed, 0);
        check("abort_pe_rst", pe_rst, 0);
        check("abort_cnt", dut.xfer_cnt_q, 0);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("abort_idle_done", done, 0);
            check("abort_idle_busy", busy, 0);
        end
        in_valid = 1'b0;

        run_tile(0, 0, 1'b1, 11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
